// File: rtl/cla_seq_addsub_if.sv
// Operand/result handshake bundle for cla_seq_addsub.
// The master drives operands and out_ready; the slave (the adder) drives the result side.
interface cla_seq_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             prop_all;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, prop_all
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, prop_all
    );
endinterface

// File: rtl/cla_seq_addsub.sv
// Multi-cycle CLA add/sub, one CHUNK-bit lookahead group per clock; result valid NCHUNK edges after accept.
// Single operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module cla_seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cla_seq_addsub_if.slave   bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("cla_seq_addsub: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic              r_prop;
    logic [WIDTH-1:0]  r_work;

    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_zero;
    logic              r_prop_all;

    logic              w_accept;
    logic              w_last;
    logic [CHUNK-1:0]  w_p;
    logic [CHUNK-1:0]  w_g;
    logic [CHUNK:0]    w_c;
    logic [CHUNK-1:0]  w_s;
    logic              w_prop_nxt;
    logic [WIDTH-1:0]  w_work_nxt;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_last   = (r_idx == LAST_IDX);

    // Operand registers shift right each RUN cycle, so the active group is always the low CHUNK bits.
    assign w_p = r_a[CHUNK-1:0] ^ r_b[CHUNK-1:0];
    assign w_g = r_a[CHUNK-1:0] & r_b[CHUNK-1:0];

    // Flattened sum-of-products lookahead: every carry is built directly from G/P and the group carry-in.
    always_comb begin
        logic acc;
        logic pp;
        acc = 1'b0;
        pp  = 1'b0;
        w_c = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < CHUNK; i++) begin
            acc = w_g[i];
            pp  = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & w_g[j]);
                pp  = pp & w_p[j];
            end
            w_c[i+1] = acc | (pp & r_carry);
        end
    end

    assign w_s        = w_p ^ w_c[CHUNK-1:0];
    assign w_prop_nxt = r_prop & (&w_p);
    // Result slices enter at the top and migrate down; after NCHUNK groups the first one sits at bit 0.
    assign w_work_nxt = (r_work >> CHUNK) | (WIDTH'(w_s) << (WIDTH - CHUNK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_prop     <= 1'b0;
            r_work     <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
            r_prop_all <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_idx   <= '0;
            r_prop  <= 1'b1;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_carry <= w_c[CHUNK];
            r_prop  <= w_prop_nxt;
            r_work  <= w_work_nxt;
            if (w_last) begin
                r_sum      <= w_work_nxt;
                r_cout     <= w_c[CHUNK];
                r_ovf      <= w_c[CHUNK-1] ^ w_c[CHUNK];
                r_zero     <= (w_work_nxt == '0);
                r_prop_all <= w_prop_nxt;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
    assign bus.prop_all  = r_prop_all;
endmodule
